fp32_div_seq: RTL and testbench

Sequential IEEE-754 single-precision divider, Out = InA / InB, the inverse of the Conv3X3 multiplier datapath.
- Used for normalisation and averaging stages, e.g. dividing accumulated sums by window or channel counts.
- Radix-2 restoring mantissa division, one quotient bit per cycle.
- Valid/ready handshake on both sides; one operation in flight.
- Truncating, with no rounding, matching the multiplier's result convention.

---
 rtl/fp32_pkg.sv | 35 +++
 rtl/fp_div_mant_step.sv | 22 ++
 rtl/fp32_div_seq.sv | 192 +++++++++++++++++++
 tb/tb_fp32_div_seq.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp32_pkg
// Purpose  : Shared FP32 field widths, constants and divider state encodings.
// Revision : 1.0 - initial release
// ============================================================================
package fp32_pkg;

  localparam int FP32_W      = 32;
  localparam int FP32_EXP_W  = 8;
  localparam int FP32_FRAC_W = 23;
  localparam int FP32_MANT_W = 24;
  localparam int EXP_BIAS    = 127;

  localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] FP32_POS_INF = 32'h7F80_0000;
  localparam logic [31:0] FP32_ZERO    = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // Result override decided at operand capture, applied in NORM.
  typedef enum logic [1:0] {
    SPC_NONE = 2'd0,
    SPC_ZERO = 2'd1,
    SPC_INF  = 2'd2,
    SPC_NAN  = 2'd3
  } div_special_t;

endpackage
`default_nettype wire

// File: rtl/fp_div_mant_step.sv
`default_nettype none
// ============================================================================
// Module   : fp_div_mant_step
// Purpose  : One combinational radix-2 restoring division step.
// Revision : 1.0 - initial release
// ============================================================================
module fp_div_mant_step (
  input  logic [25:0] i_rem,
  input  logic [23:0] i_div,
  output logic [25:0] o_rem_next,
  output logic        o_q_bit
);

  logic [24:0] w_diff;

  assign o_q_bit = (i_rem >= {2'b00, i_div});
  // The partial remainder stays below 2*div, so 25 bits hold the difference.
  assign w_diff     = i_rem[24:0] - {1'b0, i_div};
  assign o_rem_next = o_q_bit ? {w_diff, 1'b0} : {i_rem[24:0], 1'b0};

endmodule
`default_nettype wire

// File: rtl/fp32_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : fp32_div_seq
// Purpose  : Sequential truncating FP32 divider, one quotient bit per cycle.
//            Define FP32_DIV_SPECIAL_EN for full NaN/inf/saturation handling.
// Revision : 1.0 - initial release
// ============================================================================
module fp32_div_seq #(
  parameter int EXP_BIAS = fp32_pkg::EXP_BIAS,
  parameter int QBITS    = 25
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [31:0] InA,
  input  logic [31:0] InB,
  input  logic        In_Valid,
  output logic        In_Ready,
  output logic [31:0] Out,
  output logic        Out_Valid,
  input  logic        Out_Ready
);
  import fp32_pkg::*;

  div_state_t          r_state;
  div_special_t        r_special;
  logic                r_sign;
  logic signed [9:0]   r_exp;
  logic [25:0]         r_rem;
  logic [23:0]         r_div;
  logic [QBITS-1:0]    r_q;
  logic [4:0]          r_cnt;
  logic [31:0]         r_out;
  logic                r_out_valid;

  logic [7:0]          w_a_exp;
  logic [7:0]          w_b_exp;
  logic                w_a_zero;
  logic                w_b_zero;
  logic signed [9:0]   w_exp_cap;
  div_special_t        w_special_cap;
  logic [25:0]         w_rem_next;
  logic                w_q_bit;
  logic signed [9:0]   w_exp_norm;
  logic [22:0]         w_frac;
  logic [31:0]         w_result;

  assign w_a_exp  = InA[30:23];
  assign w_b_exp  = InB[30:23];
  assign w_a_zero = (w_a_exp == 8'h00);
  assign w_b_zero = (w_b_exp == 8'h00);

  assign w_exp_cap = $signed({2'b00, w_a_exp}) - $signed({2'b00, w_b_exp})
                   + $signed(10'(EXP_BIAS));

`ifdef FP32_DIV_SPECIAL_EN
  logic w_a_max;
  logic w_b_max;
  logic w_a_nan;
  logic w_b_nan;
  logic w_a_inf;
  logic w_b_inf;

  assign w_a_max = (w_a_exp == 8'hFF);
  assign w_b_max = (w_b_exp == 8'hFF);
  assign w_a_nan = w_a_max && (InA[22:0] != 23'd0);
  assign w_b_nan = w_b_max && (InB[22:0] != 23'd0);
  assign w_a_inf = w_a_max && (InA[22:0] == 23'd0);
  assign w_b_inf = w_b_max && (InB[22:0] == 23'd0);

  always_comb begin
    w_special_cap = SPC_NONE;
    if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf))
      w_special_cap = SPC_NAN;
    else if (w_a_inf)
      w_special_cap = SPC_INF;
    else if (w_b_inf)
      w_special_cap = SPC_ZERO;
    else if (w_a_zero)
      w_special_cap = SPC_ZERO;
    else if (w_b_zero)
      w_special_cap = SPC_INF;
  end
`else
  always_comb begin
    w_special_cap = SPC_NONE;
    if (w_a_zero)
      w_special_cap = SPC_ZERO;
    else if (w_b_zero)
      w_special_cap = SPC_INF;
  end
`endif

  fp_div_mant_step u_step (
    .i_rem      (r_rem),
    .i_div      (r_div),
    .o_rem_next (w_rem_next),
    .o_q_bit    (w_q_bit)
  );

  // Q[24] is the integer bit; a ratio below 1.0 needs one left shift.
  assign w_exp_norm = r_q[24] ? r_exp : (r_exp - 10'sd1);
  assign w_frac     = r_q[24] ? r_q[23:1] : r_q[22:0];

`ifdef FP32_DIV_SPECIAL_EN
  always_comb begin
    w_result = {r_sign, w_exp_norm[7:0], w_frac};
    case (r_special)
      SPC_ZERO: w_result = {r_sign, FP32_ZERO[30:0]};
      SPC_INF:  w_result = {r_sign, FP32_POS_INF[30:0]};
      SPC_NAN:  w_result = FP32_QNAN;
      default: begin
        if (w_exp_norm >= 10'sd255)
          w_result = {r_sign, FP32_POS_INF[30:0]};
        else if (w_exp_norm <= 10'sd0)
          w_result = {r_sign, FP32_ZERO[30:0]};
      end
    endcase
  end
`else
  logic w_exp_hi_unused;
  assign w_exp_hi_unused = ^w_exp_norm[9:8];

  // Exponent over/underflow wraps: only the low 8 bits reach the result.
  always_comb begin
    w_result = {r_sign, w_exp_norm[7:0], w_frac};
    case (r_special)
      SPC_ZERO: w_result = {r_sign, FP32_ZERO[30:0]};
      SPC_INF:  w_result = {r_sign, FP32_POS_INF[30:0]};
      SPC_NAN:  w_result = FP32_QNAN;
      default:  w_result = {r_sign, w_exp_norm[7:0], w_frac};
    endcase
  end
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= IDLE;
      r_special   <= SPC_NONE;
      r_sign      <= 1'b0;
      r_exp       <= '0;
      r_rem       <= '0;
      r_div       <= '0;
      r_q         <= '0;
      r_cnt       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (In_Valid) begin
            r_sign    <= InA[31] ^ InB[31];
            r_exp     <= w_exp_cap;
            r_special <= w_special_cap;
            r_rem     <= {2'b01, InA[22:0]};
            r_div     <= {1'b1, InB[22:0]};
            r_q       <= '0;
            r_cnt     <= '0;
            r_state   <= DIV;
          end
        end
        DIV: begin
          // Iterations run while cnt < QBITS; the cycle that sees cnt == QBITS hands off.
          if (r_cnt == 5'(QBITS)) begin
            r_state <= NORM;
          end else begin
            r_rem <= w_rem_next;
            r_q   <= {r_q[QBITS-2:0], w_q_bit};
            r_cnt <= r_cnt + 5'd1;
          end
        end
        NORM: begin
          r_out       <= w_result;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (Out_Ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign In_Ready  = (r_state == IDLE);
  assign Out       = r_out;
  assign Out_Valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_fp32_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp32_div_seq
// Purpose  : Randomized and directed self-checking bench for fp32_div_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp32_div_seq;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [31:0] InA;
  logic [31:0] InB;
  logic        In_Valid;
  logic        In_Ready;
  logic [31:0] Out;
  logic        Out_Valid;
  logic        Out_Ready;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clk = ~Clk;

  fp32_div_seq dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .InA       (InA),
    .InB       (InB),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .Out       (Out),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, want);
    end
  endtask

  // Truncated quotient straight from integer division of the significands.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    int          ea;
    int          eb;
    int          e;
    longint      ma;
    longint      mb;
    longint      q;
    logic [22:0] frac;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
`ifdef FP32_DIV_SPECIAL_EN
    if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0) ||
        (ea == 0 && eb == 0) || (ea == 255 && eb == 255))
      return 32'h7FC0_0000;
    if (ea == 255) return {s, 8'hFF, 23'h0};
    if (eb == 255) return {s, 31'h0};
`endif
    if (ea == 0) return {s, 31'h0};
    if (eb == 0) return {s, 8'hFF, 23'h0};
    ma = (longint'(1) << 23) + longint'(a[22:0]);
    mb = (longint'(1) << 23) + longint'(b[22:0]);
    q  = (ma << 24) / mb;
    e  = ea - eb + 127;
    if (q >= (longint'(1) << 24)) begin
      frac = 23'((q >> 1) & 64'h7F_FFFF);
    end else begin
      frac = 23'(q & 64'h7F_FFFF);
      e    = e - 1;
    end
`ifdef FP32_DIV_SPECIAL_EN
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0)   return {s, 31'h0};
`endif
    return {s, 8'(e), frac};
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] want, input string tag);
    int lat;
    @(negedge Clk);
    check({tag, "_in_ready"}, {31'b0, In_Ready}, 32'd1);
    InA      = a;
    InB      = b;
    In_Valid = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    In_Valid = 1'b0;
    InA      = $urandom;
    InB      = $urandom;
    lat      = 0;
    do begin
      @(posedge Clk);
      lat++;
      @(negedge Clk);
      if (lat == 5) check({tag, "_busy"}, {31'b0, In_Ready}, 32'd0);
    end while (!Out_Valid && lat < 60);
    check({tag, "_latency"}, 32'(lat), 32'd27);
    check({tag, "_out"}, Out, want);
    Out_Ready = 1'b1;
    @(negedge Clk);
    Out_Ready = 1'b0;
    check({tag, "_valid_clr"}, {31'b0, Out_Valid}, 32'd0);
    check({tag, "_ready_back"}, {31'b0, In_Ready}, 32'd1);
    check({tag, "_out_kept"}, Out, want);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    int          k;
    int          seen;

    Reset_n   = 1'b0;
    In_Valid  = 1'b0;
    Out_Ready = 1'b0;
    InA       = '0;
    InB       = '0;
    repeat (3) @(negedge Clk);
    check("rst_out", Out, 32'h0);
    check("rst_valid", {31'b0, Out_Valid}, 32'd0);
    check("rst_ready", {31'b0, In_Ready}, 32'd1);
    Reset_n = 1'b1;

    run_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, "six_by_two");
    run_op(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, "one_by_three");
    run_op(32'hBFC0_0000, 32'h3F00_0000, 32'hC040_0000, "neg_1p5_by_0p5");
    run_op(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, "one_by_one");
    run_op(32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, "div_by_zero");
    run_op(32'h0000_0000, 32'h4000_0000, 32'h0000_0000, "zero_dividend");
`ifdef FP32_DIV_SPECIAL_EN
    run_op(32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, "zero_by_zero");
`else
    run_op(32'h0000_0000, 32'h0000_0000, 32'h0000_0000, "zero_by_zero");
`endif
    run_op(32'h7F00_0000, 32'h0080_0000, ref_div(32'h7F00_0000, 32'h0080_0000), "exp_overflow");
    run_op(32'h0080_0000, 32'h7F00_0000, ref_div(32'h0080_0000, 32'h7F00_0000), "exp_underflow");

    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom;
      case (i % 4)
        1, 2: begin
          a[30:23] = 8'($urandom_range(100, 154));
          b[30:23] = 8'($urandom_range(100, 154));
        end
        3: begin
          case ($urandom_range(0, 3))
            0: a[30:23] = 8'h00;
            1: b[30:23] = 8'h00;
            2: a[30:23] = 8'hFF;
            default: b[30:23] = 8'hFF;
          endcase
        end
        default: ;
      endcase
      run_op(a, b, ref_div(a, b), $sformatf("rand%0d", i));
    end

    // Hold the result under backpressure while new operands are offered.
    @(negedge Clk);
    InA      = 32'h3F80_0000;
    InB      = 32'h4040_0000;
    In_Valid = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    In_Valid = 1'b0;
    k        = 0;
    while (!Out_Valid && k < 60) begin
      @(negedge Clk);
      k++;
    end
    check("bp_valid", {31'b0, Out_Valid}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      In_Valid = 1'b1;
      InA      = 32'h40C0_0000;
      InB      = 32'h4000_0000;
      @(negedge Clk);
      check($sformatf("bp_out%0d", i), Out, 32'h3EAA_AAAA);
      check($sformatf("bp_ready%0d", i), {31'b0, In_Ready}, 32'd0);
    end
    check("bp_still_valid", {31'b0, Out_Valid}, 32'd1);
    In_Valid  = 1'b0;
    Out_Ready = 1'b1;
    @(negedge Clk);
    Out_Ready = 1'b0;
    check("bp_release_ready", {31'b0, In_Ready}, 32'd1);
    check("bp_release_valid", {31'b0, Out_Valid}, 32'd0);
    check("bp_release_out", Out, 32'h3EAA_AAAA);

    // Reset while dividing: nothing from the aborted operation may appear.
    @(negedge Clk);
    InA      = 32'h3F80_0000;
    InB      = 32'h4040_0000;
    In_Valid = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    In_Valid = 1'b0;
    repeat (10) @(posedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    check("midrst_out", Out, 32'h0);
    check("midrst_valid", {31'b0, Out_Valid}, 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    check("midrst_ready", {31'b0, In_Ready}, 32'd1);
    seen = 0;
    repeat (40) begin
      @(negedge Clk);
      if (Out_Valid) seen = 1;
    end
    check("midrst_no_result", 32'(seen), 32'd0);
    run_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, "after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
